// File: rtl/cpu_pkg.sv
// Shared SPI memory arbiter types.
// Commands, arbiter states, targets and frame lengths.
package cpu_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  localparam logic [5:0] FETCH_BITS = 6'd48;
  localparam logic [5:0] DATA_BITS  = 6'd40;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DONE,
    GAP
  } arb_state_t;

  typedef enum logic {
    TGT_FLASH = 1'b0,
    TGT_RAM   = 1'b1
  } tgt_t;

endpackage

// File: rtl/spi_mem_arbiter_shift.sv
// SPI mode-0 shift engine: sclk divider, tx/rx shifters,
// bit counter and a done strobe one cycle after the last fall.
module spi_shift_engine #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [47:0] tx_data,
  input  logic [5:0]  nbits,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic [15:0] rx_data,
  output logic [5:0]  bit_cnt,
  output logic        done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          active;
  logic          tail;
  logic [DW-1:0] div_cnt;
  logic [47:0]   tx_sh;
  logic [5:0]    nbits_q;
  logic          half_end;

  assign half_end = (div_cnt == DW'(CLK_DIV - 1));
  // Unused tail bits of every frame are zero, so mosi idles low.
  assign mosi = tx_sh[47];
  assign done = tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      tail    <= 1'b0;
      div_cnt <= '0;
      sclk    <= 1'b0;
      tx_sh   <= '0;
      rx_data <= '0;
      bit_cnt <= '0;
      nbits_q <= '0;
    end else if (start) begin
      active  <= 1'b1;
      tail    <= 1'b0;
      div_cnt <= '0;
      sclk    <= 1'b0;
      tx_sh   <= tx_data;
      bit_cnt <= '0;
      nbits_q <= nbits;
    end else if (tail) begin
      active <= 1'b0;
      tail   <= 1'b0;
    end else if (active) begin
      if (!half_end) begin
        div_cnt <= div_cnt + DW'(1);
      end else begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk    <= 1'b1;
          rx_data <= {rx_data[14:0], miso};
        end else begin
          sclk    <= 1'b0;
          bit_cnt <= bit_cnt + 6'd1;
          tx_sh   <= {tx_sh[46:0], 1'b0};
          if (bit_cnt == nbits_q - 6'd1)
            tail <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Shares one SPI master between flash fetch and SPI RAM data,
// round-robin arbitration with one chip select per device.
module spi_mem_arbiter
  import cpu_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int CS_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [7:0]  d_wdata,
  output logic [7:0]  d_rdata,
  output logic        d_ready,
  output logic        spi_cs_flash_n,
  output logic        spi_cs_ram_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_sclk
);

  localparam int GW = $clog2(CS_GAP + 1);

  arb_state_t    state;
  arb_state_t    state_nx;
  tgt_t          tgt;
  logic          we_q;
  logic          prio_ram;
  logic [GW-1:0] gap_cnt;
  logic          grant;
  logic          grant_ram;
  logic [47:0]   tx_frame;
  logic [5:0]    nbits;
  logic [15:0]   rx_data;
  logic [5:0]    bit_cnt;
  logic          eng_done;
  logic          busy;

  spi_shift_engine #(
    .CLK_DIV(CLK_DIV)
  ) u_eng (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (grant),
    .tx_data(tx_frame),
    .nbits  (nbits),
    .miso   (spi_miso),
    .sclk   (spi_sclk),
    .mosi   (spi_mosi),
    .rx_data(rx_data),
    .bit_cnt(bit_cnt),
    .done   (eng_done)
  );

  // Data wins only when alone or when it holds the rr priority.
  always_comb begin
    grant     = (state == IDLE) && (if_req || d_req);
    grant_ram = d_req && (!if_req || prio_ram);
    tx_frame  = {SPI_CMD_READ, 7'b0, if_addr, 1'b0, 16'h0};
    nbits     = FETCH_BITS;
    if (grant_ram) begin
      nbits = DATA_BITS;
      if (d_we)
        tx_frame = {SPI_CMD_WRITE, 8'h0, d_addr, d_wdata, 8'h0};
      else
        tx_frame = {SPI_CMD_READ, 8'h0, d_addr, 16'h0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (grant) state_nx = CMD;
      CMD:  if (bit_cnt == 6'd8) state_nx = ADDR;
      ADDR: if (bit_cnt == 6'd32) state_nx = DATA;
      DATA: if (eng_done) state_nx = DONE;
      DONE: state_nx = GAP;
      GAP:  if (gap_cnt == GW'(CS_GAP - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CMD) || (state == ADDR) || (state == DATA);
    spi_cs_flash_n = !(busy && (tgt == TGT_FLASH));
    spi_cs_ram_n   = !(busy && (tgt == TGT_RAM));
    if_ready = (state == DONE) && (tgt == TGT_FLASH);
    d_ready  = (state == DONE) && (tgt == TGT_RAM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt      <= TGT_FLASH;
      we_q     <= 1'b0;
      prio_ram <= 1'b0;
      gap_cnt  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if (grant) begin
        tgt      <= grant_ram ? TGT_RAM : TGT_FLASH;
        we_q     <= grant_ram && d_we;
        prio_ram <= !grant_ram;
      end
      if (state == GAP)
        gap_cnt <= gap_cnt + GW'(1);
      else
        gap_cnt <= '0;
      if ((state == DATA) && eng_done) begin
        if (tgt == TGT_FLASH)
          if_rdata <= rx_data;
        else if (!we_q)
          d_rdata <= rx_data[7:0];
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter with flash/RAM models,
// plus a CLK_DIV=3 instance for divider timing.
module tb_spi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        if_ready;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [7:0]  d_wdata = '0;
  logic [7:0]  d_rdata;
  logic        d_ready;
  logic        cs_f_n, cs_r_n, mosi, sclk;
  wire         miso;

  logic        if2_req = 1'b0;
  logic [15:0] if2_addr = '0;
  logic [15:0] if2_rdata;
  logic        if2_ready;
  logic        d2_req = 1'b0;
  logic        d2_we = 1'b0;
  logic [15:0] d2_addr = '0;
  logic [7:0]  d2_wdata = '0;
  logic [7:0]  d2_rdata;
  logic        d2_ready;
  logic        cs2_f_n, cs2_r_n, mosi2, sclk2;
  wire         miso2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_mem_arbiter #(.CLK_DIV(1), .CS_GAP(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .spi_cs_flash_n(cs_f_n), .spi_cs_ram_n(cs_r_n),
    .spi_mosi(mosi), .spi_miso(miso), .spi_sclk(sclk)
  );

  spi_mem_arbiter #(.CLK_DIV(3), .CS_GAP(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if2_req), .if_addr(if2_addr),
    .if_rdata(if2_rdata), .if_ready(if2_ready),
    .d_req(d2_req), .d_we(d2_we), .d_addr(d2_addr),
    .d_wdata(d2_wdata), .d_rdata(d2_rdata), .d_ready(d2_ready),
    .spi_cs_flash_n(cs2_f_n), .spi_cs_ram_n(cs2_r_n),
    .spi_mosi(mosi2), .spi_miso(miso2), .spi_sclk(sclk2)
  );

  function automatic logic [15:0] flash_word(input logic [23:0] a);
    if (a == 24'h000004) return 16'h0650;
    return 16'hA000 | a[15:0];
  endfunction

  // Flash model for dut
  int          fc;
  logic [31:0] fsh;
  logic [15:0] fword;
  logic [7:0]  f_cmd;
  logic [23:0] f_addr;
  logic        fmiso = 1'b0;
  always @(negedge cs_f_n) fc = 0;
  always @(posedge sclk) if (!cs_f_n) begin
    if (fc < 32) fsh = {fsh[30:0], mosi};
    fc++;
    if (fc == 32) begin
      f_cmd = fsh[31:24];
      f_addr = fsh[23:0];
      fword = flash_word(fsh[23:0]);
    end
  end
  always @(negedge sclk)
    if (!cs_f_n && fc >= 32 && fc < 48) fmiso = fword[47 - fc];

  // RAM model for dut
  logic [7:0]  ram [256];
  int          rc;
  logic [39:0] rsh;
  logic [7:0]  r_cmd, r_wbyte, rb;
  logic [23:0] r_addr;
  logic        rmiso = 1'b0;
  always @(negedge cs_r_n) rc = 0;
  always @(posedge sclk) if (!cs_r_n) begin
    rsh = {rsh[38:0], mosi};
    rc++;
    if (rc == 32) begin
      r_cmd = rsh[31:24];
      r_addr = rsh[23:0];
    end
    if (rc == 40 && r_cmd == 8'h02) begin
      r_wbyte = rsh[7:0];
      ram[r_addr[7:0]] = rsh[7:0];
    end
  end
  always @(negedge sclk)
    if (!cs_r_n && rc >= 32 && rc < 40 && r_cmd == 8'h03) begin
      rb = ram[r_addr[7:0]];
      rmiso = rb[39 - rc];
    end

  assign miso = !cs_f_n ? fmiso : (!cs_r_n ? rmiso : 1'b0);

  // Flash model for dut2
  int          fc2;
  logic [31:0] fsh2;
  logic [15:0] fword2;
  logic [23:0] f2_addr;
  logic        fmiso2 = 1'b0;
  always @(negedge cs2_f_n) fc2 = 0;
  always @(posedge sclk2) if (!cs2_f_n) begin
    if (fc2 < 32) fsh2 = {fsh2[30:0], mosi2};
    fc2++;
    if (fc2 == 32) begin
      f2_addr = fsh2[23:0];
      fword2 = flash_word(fsh2[23:0]);
    end
  end
  always @(negedge sclk2)
    if (!cs2_f_n && fc2 >= 32 && fc2 < 48) fmiso2 = fword2[47 - fc2];
  assign miso2 = !cs2_f_n ? fmiso2 : 1'b0;

  // Bus monitor
  logic       pf = 1'b1, pr = 1'b1;
  logic       both_low = 1'b0;
  logic [5:0] order = '0;
  int f_frames = 0, r_frames = 0;
  int hi_run = 0, min_gap = 999;
  int if_pulses = 0, d_pulses = 0;
  always @(posedge clk) begin
    if (!cs_f_n && !cs_r_n) both_low = 1'b1;
    if (pf && !cs_f_n) begin f_frames++; order = {order[4:0], 1'b0}; end
    if (pr && !cs_r_n) begin r_frames++; order = {order[4:0], 1'b1}; end
    pf = cs_f_n;
    pr = cs_r_n;
    if (cs_f_n && cs_r_n) hi_run++;
    else begin
      if (hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
      hi_run = 0;
    end
    if (if_ready) if_pulses++;
    if (d_ready) d_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_if(input int maxc, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!if_ready && lat < maxc);
  endtask

  task automatic wait_d(input int maxc, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!d_ready && lat < maxc);
  endtask

  int lat, n, cyc, p0, rf0;
  logic [11:0] hist;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    tick(3);
    chk("rst_cs_flash", cs_f_n, 1);
    chk("rst_cs_ram", cs_r_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst_n = 1'b1;
    tick(2);

    // 1: fetch only
    if_addr = 16'h0002; if_req = 1'b1;
    wait_if(200, lat);
    if_req = 1'b0;
    chk("t1_latency", lat, 98);
    chk("t1_rdata", if_rdata, 16'h0650);
    chk("t1_cmd", f_cmd, 8'h03);
    chk("t1_addr", f_addr, 24'h000004);
    tick(4);
    chk("t1_pulses", if_pulses, 1);
    chk("t1_ram_idle", r_frames, 0);

    // 2: data write then read
    d_we = 1'b1; d_addr = 16'h0000; d_wdata = 8'h1E; d_req = 1'b1;
    wait_d(200, lat);
    d_req = 1'b0;
    chk("t2_wr_latency", lat, 82);
    chk("t2_wr_cmd", r_cmd, 8'h02);
    chk("t2_wr_addr", r_addr, 24'h000000);
    chk("t2_wr_byte", r_wbyte, 8'h1E);
    chk("t2_wr_rdata_hold", d_rdata, 8'h00);
    tick(4);
    d_we = 1'b0; d_wdata = 8'hFF; d_req = 1'b1;
    wait_d(200, lat);
    d_req = 1'b0;
    chk("t2_rd_latency", lat, 82);
    chk("t2_rd_data", d_rdata, 8'h1E);
    chk("t2_rd_cmd", r_cmd, 8'h03);
    chk("t2_if_hold", if_rdata, 16'h0650);
    tick(4);
    chk("t2_pulses", d_pulses, 2);

    // 3: simultaneous requests, round robin
    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
    order = '0; min_gap = 999; both_low = 1'b0;
    if_addr = 16'h0010; d_addr = 16'h0000; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
      if (if_ready) begin n++; if_req = 1'b0; end
      if (d_ready) begin n++; d_req = 1'b0; end
    end
    tick(4);
    if_req = 1'b1; d_req = 1'b1;
    while (n < 6 && cyc < 2000) begin
      @(posedge clk); #1; cyc++;
      if (if_ready || d_ready) n++;
      if (n == 6) begin if_req = 1'b0; d_req = 1'b0; end
    end
    tick(6);
    chk("t3_ready_count", n, 6);
    chk("t3_order", order, 6'b010101);
    chk("t3_cs_both_low", both_low, 0);
    chk("t3_gap_ok", (min_gap >= 2), 1);
    chk("t3_if_rdata", if_rdata, 16'hA020);
    chk("t3_d_rdata", d_rdata, 8'h1E);

    // 4: CLK_DIV=3 fetch
    if2_addr = 16'h0001; if2_req = 1'b1;
    lat = 0; hist = '0;
    do begin
      @(posedge clk); #1; lat++;
      if (lat <= 12) hist = {hist[10:0], sclk2};
    end while (!if2_ready && lat < 1000);
    if2_req = 1'b0;
    chk("t4_latency", lat, 290);
    chk("t4_rdata", if2_rdata, 16'hA002);
    chk("t4_addr", f2_addr, 24'h000002);
    chk("t4_sclk_shape", hist, 12'b000111000111);

    // 5: reset mid-ADDR of a data read
    tick(4);
    d_we = 1'b0; d_addr = 16'h0000; d_req = 1'b1;
    tick(10);
    if_addr = 16'h0002; if_req = 1'b1;
    tick(20);
    chk("t5_in_frame", cs_r_n, 0);
    p0 = d_pulses;
    rst_n = 1'b0;
    #1;
    chk("t5_cs_flash", cs_f_n, 1);
    chk("t5_cs_ram", cs_r_n, 1);
    chk("t5_sclk", sclk, 0);
    chk("t5_d_ready", d_ready, 0);
    chk("t5_if_rdata", if_rdata, 0);
    d_req = 1'b0;
    tick(2);
    rst_n = 1'b1;
    wait_if(200, lat);
    if_req = 1'b0;
    chk("t5_fetch_latency", lat, 98);
    chk("t5_fetch_rdata", if_rdata, 16'h0650);
    chk("t5_no_d_ready", d_pulses, p0);

    // 6: d_req dropped after grant
    tick(4);
    p0 = d_pulses; rf0 = r_frames;
    d_we = 1'b0; d_addr = 16'h0000; d_req = 1'b1;
    tick(1);
    d_req = 1'b0;
    wait_d(200, lat);
    chk("t6_latency", lat + 1, 82);
    chk("t6_rdata", d_rdata, 8'h1E);
    tick(120);
    chk("t6_one_pulse", d_pulses - p0, 1);
    chk("t6_no_regrant", r_frames - rf0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
